uart_rx_fifo: RTL and testbench

//  Standalone UART receiver with RX FIFO: 8N1, LSB first, bit period = baud_div clocks.

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: frame width, line idle level and receiver FSM states.
package uart_rx_fifo_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is ignored so the oldest data survives.
module uart_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = UART_DATA_BITS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic [AW:0]       count_next;
    logic              empty_q;
    logic              push_ok;
    logic              pop_ok;

    // Both operations judge against the pre-update state.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        count_next = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            empty_q <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count_q == FULL_CNT);
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding an RX FIFO; bytes are popped by toggling uart_rx_read.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   baud_div,
    input  logic          uart_rx_pin,
    input  logic          uart_rx_read,
    input  logic          uart_rx_clr_err,
    output logic          uart_rx_ready,
    output logic [7:0]    uart_rx_byte,
    output logic [CW-1:0] uart_rx_count,
    output logic          uart_rx_frame_err,
    output logic          uart_rx_overflow
);

    logic           rx_sync_p0;
    logic           rx_sync_p1;
    logic           rx;
    uart_rx_state_t state;
    logic [15:0]    timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           read_q;
    logic           expire;
    logic           push_evt;
    logic           ferr_evt;
    logic           ovf_evt;
    logic           pop_req;
    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

    // Stage p0/p1: two-flop synchronizer on the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= UART_IDLE_LVL;
            rx_sync_p1 <= UART_IDLE_LVL;
        end else begin
            rx_sync_p0 <= uart_rx_pin;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx       = rx_sync_p1;
    assign expire   = (timer == 16'd1);
    assign push_evt = (state == ST_STOP) && expire && (rx == UART_IDLE_LVL);
    assign ferr_evt = (state == ST_STOP) && expire && (rx != UART_IDLE_LVL);
    assign ovf_evt  = push_evt && fifo_full;
    assign pop_req  = (uart_rx_read != read_q);

    // IDLE is only ever entered with the line high, so a low rx there is a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx != UART_IDLE_LVL) begin
                        state <= ST_START;
                        timer <= baud_div >> 1;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (rx != UART_IDLE_LVL) begin
                            state   <= ST_DATA;
                            timer   <= baud_div;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        timer <= baud_div;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (expire) state <= push_evt ? ST_IDLE : ST_BREAK;
                    else timer <= timer - 16'd1;
                end
                ST_BREAK: begin
                    if (rx == UART_IDLE_LVL) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_DATA && expire) shreg <= {rx, shreg[7:1]};
    end

    // read_q follows the toggle even in reset, so a stale level never pops.
    always_ff @(posedge clk) begin
        read_q <= uart_rx_read;
        if (rst) begin
            uart_rx_byte      <= 8'h00;
            uart_rx_frame_err <= 1'b0;
            uart_rx_overflow  <= 1'b0;
        end else begin
            if (pop_req) uart_rx_byte <= fifo_empty ? 8'h00 : fifo_head;
            if (ferr_evt) uart_rx_frame_err <= 1'b1;
            else if (uart_rx_clr_err) uart_rx_frame_err <= 1'b0;
            if (ovf_evt) uart_rx_overflow <= 1'b1;
            else if (uart_rx_clr_err) uart_rx_overflow <= 1'b0;
        end
    end

    uart_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_evt),
        .push_data (shreg),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (uart_rx_count)
    );

    assign uart_rx_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial line driver, queue-based receive model and per-cycle status compare.
module tb_uart_rx_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd434;
    logic        pin = 1'b1;
    logic        rd = 1'b0;
    logic        clr = 1'b0;
    logic        ready;
    logic [7:0]  rbyte;
    logic [6:0]  count;
    logic        ferr;
    logic        ovf;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    byte unsigned mq[$];
    bit m_ferr = 1'b0;
    bit m_ovf = 1'b0;

    always #10 clk = ~clk;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .baud_div          (baud_div),
        .uart_rx_pin       (pin),
        .uart_rx_read      (rd),
        .uart_rx_clr_err   (clr),
        .uart_rx_ready     (ready),
        .uart_rx_byte      (rbyte),
        .uart_rx_count     (count),
        .uart_rx_frame_err (ferr),
        .uart_rx_overflow  (ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Status outputs against the model on every settled cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", int'(ready), int'(mq.size() != 0));
            chk("count", int'(count), mq.size());
            chk("frame_err", int'(ferr), int'(m_ferr));
            chk("overflow", int'(ovf), int'(m_ovf));
        end
    end

    // One 8N1 frame; with tog set, the read toggle lands on the cycle the stop bit pushes.
    task automatic send_byte(input logic [7:0] d, input logic stop_lvl, input bit tog);
        int b;
        int h;
        int exp;
        b = int'(baud_div);
        h = b / 2;
        exp = 0;
        chk_en = 1'b0;
        @(posedge clk); #1 pin = 1'b0;
        repeat (b) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 pin = d[i];
            repeat (b) @(posedge clk);
        end
        #1 pin = stop_lvl;
        if (tog) begin
            repeat (h + 2) @(posedge clk);
            #1 rd = ~rd;
            repeat (b - h - 2) @(posedge clk);
        end else begin
            repeat (b) @(posedge clk);
        end
        #1 pin = 1'b1;
        if (tog) exp = (mq.size() != 0) ? int'(mq.pop_front()) : 0;
        if (stop_lvl) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        if (tog) chk("byte_at_push", int'(rbyte), exp);
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    task automatic pop_chk(input string name, input int lit);
        int exp;
        chk_en = 1'b0;
        @(posedge clk); #1 rd = ~rd;
        @(posedge clk); #1;
        exp = (mq.size() != 0) ? int'(mq.pop_front()) : 0;
        chk(name, int'(rbyte), exp);
        if (lit >= 0) chk({name, "_lit"}, int'(rbyte), lit);
        chk_en = 1'b1;
    endtask

    task automatic clr_err();
        chk_en = 1'b0;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        m_ferr = 1'b0;
        m_ovf = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        m_ferr = 1'b0;
        m_ovf = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int npop;
        bit bad;

        // Reset, with the read toggle moving while reset is held.
        repeat (2) @(posedge clk);
        #1 rd = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", int'(ready), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_byte", int'(rbyte), 0);
        chk("rst_frame_err", int'(ferr), 0);
        chk("rst_overflow", int'(ovf), 0);
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stale_toggle_byte", int'(rbyte), 0);
        pop_chk("idle_pop", 0);
        chk("idle_pop_count", int'(count), 0);

        // Four frames at the full divider.
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        chk("four_count", int'(count), 4);
        chk("four_ready", int'(ready), 1);
        pop_chk("pop0", 8'h00);
        pop_chk("pop1", 8'h55);
        pop_chk("pop2", 8'hA5);
        pop_chk("pop3", 8'hFF);
        chk("drained_ready", int'(ready), 0);

        // Short start glitch must be rejected.
        chk_en = 1'b0;
        @(posedge clk); #1 pin = 1'b0;
        repeat (100) @(posedge clk);
        #1 pin = 1'b1;
        repeat (600) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("glitch_count", int'(count), 0);
        send_byte(8'h81, 1'b1, 1'b0);
        pop_chk("after_glitch", 8'h81);

        @(posedge clk); #1 baud_div = 16'd16;

        // Overflow: 70 frames into 64 slots, oldest kept.
        for (int i = 0; i < 70; i++) begin
            d = i[7:0];
            send_byte(d, 1'b1, 1'b0);
        end
        chk("ovf_count", int'(count), 64);
        chk("ovf_flag", int'(ovf), 1);
        for (int i = 0; i < 64; i++) pop_chk("ovf_drain", i);
        clr_err();
        chk("ovf_cleared", int'(ovf), 0);

        // Framing error, clear, then recovery.
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("ferr_flag", int'(ferr), 1);
        chk("ferr_count", int'(count), 0);
        clr_err();
        chk("ferr_cleared", int'(ferr), 0);
        send_byte(8'h12, 1'b1, 1'b0);
        pop_chk("after_ferr", 8'h12);

        // Pop on the exact push cycle.
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b1);
        chk("same_cycle_byte", int'(rbyte), 8'h11);
        chk("same_cycle_count", int'(count), 2);
        pop_chk("same_cycle_pop1", 8'h22);
        pop_chk("same_cycle_pop2", 8'h33);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            d = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_byte(d, !bad, 1'b0);
            npop = $urandom_range(0, 3);
            for (int k = 0; k < npop; k++) pop_chk("rand_pop", -1);
            if ($urandom_range(0, 9) == 0) clr_err();
        end

        // Reset in the middle of a frame.
        send_byte(8'h44, 1'b1, 1'b0);
        chk_en = 1'b0;
        @(posedge clk); #1 pin = 1'b0;
        repeat (48) @(posedge clk);
        #1 pin = 1'b1;
        do_reset();
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_ready", int'(ready), 0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_byte", int'(count), 0);
        send_byte(8'h5A, 1'b1, 1'b0);
        pop_chk("after_rst", 8'h5A);

        repeat (5) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
